// File: rtl/regfile_scoreboard_if.sv
// Decode-side bundle for the register file: two read ports, the write-back port,
// the issue request, and the hazard/scoreboard status returned to issue logic.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_use_rs1;
  logic              issue_use_rs2;
  logic              issue_has_rd;
  logic              stall;
  logic [NREG-1:0]   busy;
  logic              wb_err;

  modport master (
    output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data,
           issue_valid, issue_rd, issue_use_rs1, issue_use_rs2, issue_has_rd,
    input  rs1_data, rs2_data, stall, busy, wb_err
  );

  modport slave (
    input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data,
           issue_valid, issue_rd, issue_use_rs1, issue_use_rs2, issue_has_rd,
    output rs1_data, rs2_data, stall, busy, wb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// RV32E register file with write-to-read bypass and a per-register busy
// scoreboard that stalls issue on RAW/WAW hazards against in-flight writes.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int ADDR_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);
  localparam logic [ADDR_W-1:0] X0 = {ADDR_W{1'b0}};

  logic [DATA_W-1:0] regs_r [NREG];
  logic [NREG-1:0]   busy_r;
  logic              wb_err_r;

  logic              wr_live_s;
  logic [NREG-1:0]   clr_s;
  logic [NREG-1:0]   set_s;
  logic [NREG-1:0]   busy_next_s;
  logic              raw1_s;
  logic              raw2_s;
  logic              waw_s;
  logic              stall_s;
  logic [DATA_W-1:0] rs1_s;
  logic [DATA_W-1:0] rs2_s;

  // Operand reads: x0 reads zero, a same-cycle write-back is forwarded.
  always_comb begin
    rs1_s = {DATA_W{1'b0}};
    rs2_s = {DATA_W{1'b0}};
    if (bus.rs1_addr == X0) begin
      rs1_s = {DATA_W{1'b0}};
    end else if (bus.wr_en && (bus.wr_addr == bus.rs1_addr)) begin
      rs1_s = bus.wr_data;
    end else begin
      rs1_s = regs_r[bus.rs1_addr];
    end
    if (bus.rs2_addr == X0) begin
      rs2_s = {DATA_W{1'b0}};
    end else if (bus.wr_en && (bus.wr_addr == bus.rs2_addr)) begin
      rs2_s = bus.wr_data;
    end else begin
      rs2_s = regs_r[bus.rs2_addr];
    end
  end

  // Hazard detection; a register retiring this cycle no longer blocks issue.
  always_comb begin
    wr_live_s = bus.wr_en && (bus.wr_addr != X0);
    clr_s     = {NREG{1'b0}};
    if (wr_live_s) begin
      clr_s[bus.wr_addr] = 1'b1;
    end else begin
      clr_s = {NREG{1'b0}};
    end
    raw1_s  = bus.issue_use_rs1 && (bus.rs1_addr != X0) &&
              busy_r[bus.rs1_addr] && !clr_s[bus.rs1_addr];
    raw2_s  = bus.issue_use_rs2 && (bus.rs2_addr != X0) &&
              busy_r[bus.rs2_addr] && !clr_s[bus.rs2_addr];
    waw_s   = bus.issue_has_rd && (bus.issue_rd != X0) &&
              busy_r[bus.issue_rd] && !clr_s[bus.issue_rd];
    stall_s = bus.issue_valid && (raw1_s || raw2_s || waw_s);
  end

  // Next scoreboard: clear on write-back, then set on issue so set wins.
  always_comb begin
    set_s = {NREG{1'b0}};
    if (bus.issue_valid && !stall_s && bus.issue_has_rd && (bus.issue_rd != X0)) begin
      set_s[bus.issue_rd] = 1'b1;
    end else begin
      set_s = {NREG{1'b0}};
    end
    busy_next_s    = (busy_r & ~clr_s) | set_s;
    busy_next_s[0] = 1'b0;
  end

  // Register array, scoreboard and sticky error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      busy_r   <= {NREG{1'b0}};
      wb_err_r <= 1'b0;
    end else begin
      if (wr_live_s) begin
        regs_r[bus.wr_addr] <= bus.wr_data;
      end
      if (wr_live_s && !busy_r[bus.wr_addr]) begin
        wb_err_r <= 1'b1;
      end
      busy_r <= busy_next_s;
    end
  end

  assign bus.rs1_data = rs1_s;
  assign bus.rs2_data = rs2_s;
  assign bus.stall    = stall_s;
  assign bus.busy     = busy_r;
  assign bus.wb_err   = wb_err_r;
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- 16-entry x 32-bit integer register file (RV32E register space) with two asynchronous read ports, one synchronous write-back port, and a per-register busy scoreboard.
- Sits upstream of the operand-select muxes in decode. It supplies rs1/rs2 operand data and raises a stall to the issue logic on RAW/WAW hazards against in-flight writes.
- Write-to-read bypass is built in, so the decode stage sees same-cycle write-back data.

Parameters:
DATA_W, 32, register width in bits
NREG, 16, number of architectural registers (x0..x15)
ADDR_W, 4, register address width (log2 NREG)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
rs1_addr  input  ADDR_W  read port 1 address
rs2_addr  input  ADDR_W  read port 2 address
rs1_data  output  DATA_W  read port 1 data (combinational)
rs2_data  output  DATA_W  read port 2 data (combinational)
wr_en  input  1  write-back valid
wr_addr  input  ADDR_W  write-back destination
wr_data  input  DATA_W  write-back data
issue_valid  input  1  decode presents an instruction this cycle
issue_rd  input  ADDR_W  destination of issuing instruction
issue_use_rs1  input  1  instruction reads rs1_addr
issue_use_rs2  input  1  instruction reads rs2_addr
issue_has_rd  input  1  instruction writes issue_rd
stall  output  1  issue blocked this cycle (combinational)
busy  output  NREG  scoreboard bit vector; bit 0 always 0
wb_err  output  1  sticky: write-back to a non-busy register occurred

Behaviour:
Reset:
- rst sampled high at a clock edge clears all registers to 0, busy to 0 and wb_err to 0.
- rst overrides any wr_en or issue in the same cycle; in-flight busy state is discarded.

Reads (combinational, 0 latency):
- rsN_data = 0 if rsN_addr==0.
- Otherwise rsN_data = wr_data if wr_en && wr_addr==rsN_addr.
- Otherwise rsN_data = reg[rsN_addr].

Writes:
- On the clock edge with wr_en && wr_addr!=0: reg[wr_addr] <= wr_data.
- Writes to x0 are discarded and have no scoreboard effect.

Hazard/stall (combinational):
- clr[i] = wr_en && wr_addr==i && i!=0. A register that is being written this cycle counts as not busy for hazard checks.
- raw1 = issue_use_rs1 && rs1_addr!=0 && busy[rs1_addr] && !clr[rs1_addr]; raw2 is the same for rs2.
- waw = issue_has_rd && issue_rd!=0 && busy[issue_rd] && !clr[issue_rd].
- stall = issue_valid && (raw1 || raw2 || waw). stall = 0 whenever issue_valid = 0.

Scoreboard update (clock edge, rst low):
- When wr_en && wr_addr!=0, clear busy[wr_addr].
- When issue_valid && !stall && issue_has_rd && issue_rd!=0, set busy[issue_rd].
- If set and clear target the same index in one cycle, set wins: the register ends busy for the newly issued instruction.
- busy[0] is hardwired 0.

Error flag:
- When wr_en && wr_addr!=0 && !busy[wr_addr] at the edge, wb_err <= 1. The write is still performed.
- wb_err is cleared only by rst.

Width rules: no arithmetic is performed; addresses are compared at full ADDR_W.

Test Plan:
1. Reset, then read all 16 addresses on both ports -> every rsN_data = 0x00000000; busy = 0x0000; stall = 0; wb_err = 0.
2. Issue rd=5 (has_rd=1), next cycle issue an instruction with use_rs1=1, rs1_addr=5 -> stall=1 and busy=0x0020. Then apply wr_en, wr_addr=5, wr_data=0xDEADBEEF -> in that same cycle stall=0 and rs1_data=0xDEADBEEF (bypass). Next cycle busy[5]=0 and the array read returns 0xDEADBEEF.
3. wr_en to x0 with data 0x12345678, and issue with rd=0 -> rs1_data at addr 0 stays 0; busy stays 0x0000; wb_err stays 0; stall never asserted.
4. busy[3] set; in one cycle wr_en wr_addr=3 and an unstalled issue with rd=3 -> stall=0; after the edge busy[3]=1 (set wins) and reg[3] = written data.
5. wr_en wr_addr=7 while busy[7]=0, data 0x0000ABCD -> after the edge reg[7]=0x0000ABCD and wb_err=1. wb_err stays 1 through later traffic until rst pulses.
6. busy=0x00F0 with register values loaded, assert rst for one cycle together with wr_en wr_addr=4 -> after the edge busy=0x0000, all registers read 0, wb_err=0.
